// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction fetch/timing sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    localparam logic [1:0] ARF_DEC  = 2'b00;
    localparam logic [1:0] ARF_INC  = 2'b01;
    localparam logic [1:0] ARF_LOAD = 2'b10;
    localparam logic [1:0] ARF_CLR  = 2'b11;

    localparam logic [3:0] REGSEL_NONE = 4'b1111;
    localparam logic [3:0] REGSEL_PC   = 4'b0111;

    localparam logic [1:0] IR_LOAD = 2'b10;
    localparam logic [1:0] IR_HOLD = 2'b00;

    localparam logic [2:0] T_FETCH_L = 3'd0;
    localparam logic [2:0] T_FETCH_H = 3'd1;
    localparam logic [2:0] T_EXEC0   = 3'd2;
    localparam logic [2:0] T_SAT     = 3'd7;

    // Opcode field of a 16-bit instruction word.
    function automatic logic [3:0] opcode_of(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/seq_counter.sv
// 3-bit timing counter: synchronous clear, increment that saturates at 7, async reset.
module seq_counter
    import seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] cnt_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (inc_i && (cnt_q != T_SAT)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: two-byte instruction fetch, execute timing counter,
// halt detection and execute timeout for the ALU_System datapath.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MAX_EXEC_CYCLES = 6,
    parameter logic [3:0]  HALT_OPCODE     = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        ExecDone,
    input  logic [15:0] IROut,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic [1:0]  ARF_OutDSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [2:0]  T,
    output logic [3:0]  Opcode,
    output logic        Halted,
    output logic        Fault
);

    localparam logic [2:0] T_LAST = 3'(MAX_EXEC_CYCLES + 1);

    state_e state_q, state_d;
    logic   fault_q, fault_d;
    logic   cnt_clr, cnt_inc;
    logic   is_fetch;

    seq_counter u_counter (
        .clk_i (Clock),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (T)
    );

    assign Opcode = opcode_of(IROut);

    always_comb begin
        state_d = state_q;
        fault_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (Enable) begin
                    state_d = S_FETCH_L;
                end
            end
            S_FETCH_L: begin
                cnt_inc = 1'b1;
                state_d = S_FETCH_H;
            end
            S_FETCH_H: begin
                cnt_inc = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Halt check comes first, so a decoder's ExecDone for the halt opcode is moot.
                if ((T == T_EXEC0) && (Opcode == HALT_OPCODE)) begin
                    state_d = S_HALT;
                    cnt_clr = 1'b1;
                end else if (ExecDone || (T == T_LAST)) begin
                    state_d = Enable ? S_FETCH_L : S_IDLE;
                    cnt_clr = 1'b1;
                    fault_d = ~ExecDone;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HALT: begin
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Moore decode: reset drops state_q asynchronously, so controls go inactive at once.
    assign is_fetch = (state_q == S_FETCH_L) || (state_q == S_FETCH_H);

    always_comb begin
        ARF_FunSel  = ARF_INC;
        ARF_OutDSel = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = ~is_fetch;
        IR_Enable   = is_fetch;
        IR_LH       = (state_q == S_FETCH_H);
        IR_Funsel   = is_fetch ? IR_LOAD : IR_HOLD;
        ARF_RegSel  = is_fetch ? REGSEL_PC : REGSEL_NONE;
    end

    assign Halted = (state_q == S_HALT);
    assign Fault  = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural memory/PC/IR model.
module tb_fetch_sequencer;

    logic        Clock, Reset, Enable, ExecDone;
    logic [15:0] IROut;
    logic [1:0]  ARF_FunSel, ARF_OutDSel, IR_Funsel;
    logic [3:0]  ARF_RegSel, Opcode;
    logic        IR_LH, IR_Enable, Mem_CS, Mem_WR, Halted, Fault;
    logic [2:0]  T;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [256];
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        pc_set;
    logic [7:0]  pc_set_val;

    fetch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .ExecDone(ExecDone), .IROut(IROut),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .ARF_OutDSel(ARF_OutDSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .T(T), .Opcode(Opcode),
        .Halted(Halted), .Fault(Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Datapath model: ARF PC and byte-loaded IR reacting to the control lines.
    always @(posedge Clock) begin
        if (pc_set) pc <= pc_set_val;
        else if (ARF_RegSel[3] == 1'b0) begin
            case (ARF_FunSel)
                2'b00:   pc <= pc - 8'd1;
                2'b01:   pc <= pc + 8'd1;
                2'b11:   pc <= 8'd0;
                default: pc <= pc;
            endcase
        end
        if (!Mem_CS && !Mem_WR && IR_Enable && IR_Funsel == 2'b10 && ARF_OutDSel == 2'b00) begin
            if (IR_LH) ir[15:8] <= mem[pc];
            else       ir[7:0]  <= mem[pc];
        end
    end
    assign IROut = ir;

    logic [13:0] ctl;
    assign ctl = {Mem_CS, Mem_WR, ARF_OutDSel, IR_Enable, IR_LH, IR_Funsel, ARF_FunSel, ARF_RegSel};

    function automatic logic [13:0] exp_ctl(input logic fetch, input logic lh);
        if (fetch) return {1'b0, 1'b0, 2'b00, 1'b1, lh, 2'b10, 2'b01, 4'b0111};
        return {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1111};
    endfunction

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1; Enable = 1'b0; ExecDone = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_set = 1'b1; pc_set_val = v;
        step();
        pc_set = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Enable = 1'b0; ExecDone = 1'b0; pc_set = 1'b0; pc_set_val = 8'h00;
        #2;
        checks++; if (ctl !== exp_ctl(1'b0, 1'b0)) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, exp_ctl(1'b0, 1'b0)); end
        checks++; if ({T, Halted, Fault} !== 5'b0) begin failures++; $display("FAIL reset_T_halt_fault got=%b exp=00000", {T, Halted, Fault}); end
        step();
        Reset = 1'b0;
        step();
        checks++; if (ctl !== exp_ctl(1'b0, 1'b0) || T !== 3'd0) begin failures++; $display("FAIL idle_hold ctl=%b T=%0d", ctl, T); end
        $display("tb: reset done");
    endtask

    task automatic test_basic_fetch;
        do_reset();
        set_pc(8'h10);
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        Enable = 1'b1;
        step();
        checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b1, 1'b0)) begin failures++; $display("FAIL basic_fetchl T=%0d ctl=%b exp T=0 ctl=%b", T, ctl, exp_ctl(1'b1, 1'b0)); end
        step();
        checks++; if (T !== 3'd1 || ctl !== exp_ctl(1'b1, 1'b1)) begin failures++; $display("FAIL basic_fetchh T=%0d ctl=%b exp T=1 ctl=%b", T, ctl, exp_ctl(1'b1, 1'b1)); end
        step();
        checks++; if (T !== 3'd2 || ctl !== exp_ctl(1'b0, 1'b0)) begin failures++; $display("FAIL basic_exec T=%0d ctl=%b exp T=2", T, ctl); end
        checks++; if (IROut !== 16'h1234 || Opcode !== 4'h1) begin failures++; $display("FAIL basic_ir got=%h op=%h exp=1234 op=1", IROut, Opcode); end
        checks++; if (pc !== 8'h12) begin failures++; $display("FAIL basic_pc got=%h exp=12", pc); end
        ExecDone = 1'b1;
        step();
        ExecDone = 1'b0;
        checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b1, 1'b0)) begin failures++; $display("FAIL basic_next T=%0d ctl=%b exp T=0 fetch", T, ctl); end
        $display("tb: basic fetch IR=%h PC=%h", IROut, pc);
    endtask

    // Runs one instruction to T=7; done_at7 selects ExecDone coincident with the timeout.
    task automatic run_to_t7(input string name, input logic done_at7, input logic [7:0] base);
        do_reset();
        set_pc(base);
        mem[base] = 8'hBC; mem[8'(base + 8'd1)] = 8'h2A;
        Enable = 1'b1;
        step(); step(); step();
        for (int t = 2; t <= 7; t++) begin
            checks++; if (T !== 3'(t) || ctl !== exp_ctl(1'b0, 1'b0) || Fault !== 1'b0) begin failures++; $display("FAIL %s_exec T=%0d exp=%0d Fault=%b", name, T, t, Fault); end
            ExecDone = (t == 7) ? done_at7 : 1'b0;
            step();
        end
        ExecDone = 1'b0;
        checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b1, 1'b0)) begin failures++; $display("FAIL %s_refetch T=%0d ctl=%b", name, T, ctl); end
        checks++; if (Fault !== ~done_at7) begin failures++; $display("FAIL %s_fault got=%b exp=%b", name, Fault, ~done_at7); end
        step();
        checks++; if (Fault !== 1'b0 || T !== 3'd1) begin failures++; $display("FAIL %s_fault_pulse Fault=%b T=%0d exp 0,1", name, Fault, T); end
        $display("tb: %s done", name);
    endtask

    task automatic test_timeout;
        run_to_t7("timeout", 1'b0, 8'h30);
    endtask

    task automatic test_priority;
        run_to_t7("priority", 1'b1, 8'h38);
    endtask

    task automatic test_enable_drop;
        do_reset();
        set_pc(8'h60);
        mem[8'h60] = 8'h78; mem[8'h61] = 8'h56; mem[8'h62] = 8'hCD; mem[8'h63] = 8'hAB;
        Enable = 1'b1;
        step(); step();
        Enable = 1'b0;
        step();
        checks++; if (T !== 3'd2 || IROut !== 16'h5678) begin failures++; $display("FAIL drop_exec T=%0d IR=%h exp 2,5678", T, IROut); end
        step();
        ExecDone = 1'b1;
        step();
        ExecDone = 1'b0;
        checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b0, 1'b0) || Fault !== 1'b0) begin failures++; $display("FAIL drop_idle T=%0d ctl=%b Fault=%b", T, ctl, Fault); end
        step(); step();
        checks++; if (ctl !== exp_ctl(1'b0, 1'b0) || pc !== 8'h62) begin failures++; $display("FAIL drop_stay ctl=%b pc=%h exp pc=62", ctl, pc); end
        Enable = 1'b1;
        step(); step(); step();
        checks++; if (T !== 3'd2 || IROut !== 16'hABCD || pc !== 8'h64) begin failures++; $display("FAIL drop_resume T=%0d IR=%h pc=%h exp 2,abcd,64", T, IROut, pc); end
        $display("tb: enable drop done");
    endtask

    task automatic test_async_reset;
        do_reset();
        set_pc(8'h50);
        Enable = 1'b1;
        step(); step();
        checks++; if (ctl !== exp_ctl(1'b1, 1'b1)) begin failures++; $display("FAIL areset_pre ctl=%b exp=%b", ctl, exp_ctl(1'b1, 1'b1)); end
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (ctl !== exp_ctl(1'b0, 1'b0) || T !== 3'd0) begin failures++; $display("FAIL areset_async ctl=%b T=%0d exp=%b T=0", ctl, T, exp_ctl(1'b0, 1'b0)); end
        Enable = 1'b0;
        step();
        Reset = 1'b0;
        step();
        checks++; if (ctl !== exp_ctl(1'b0, 1'b0) || pc !== 8'h51) begin failures++; $display("FAIL areset_after ctl=%b pc=%h exp pc=51", ctl, pc); end
        $display("tb: async reset done");
    endtask

    // Random instructions: expectation derived from each instruction's ExecDone time and Enable.
    task automatic test_random;
        logic [7:0]  exp_pc;
        logic [15:0] w;
        logic        en, fault_exp;
        int          done_at, t_end;
        do_reset();
        exp_pc = 8'h80;
        set_pc(exp_pc);
        fault_exp = 1'b0;
        Enable = 1'b1;
        step();
        for (int n = 0; n < 40; n++) begin
            w = {4'($urandom_range(0, 14)), 12'($urandom)};
            mem[exp_pc] = w[7:0];
            mem[8'(exp_pc + 8'd1)] = w[15:8];
            done_at = $urandom_range(2, 8);
            en = 1'($urandom);
            t_end = (done_at <= 7) ? done_at : 7;
            checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b1, 1'b0) || Fault !== fault_exp) begin failures++; $display("FAIL rnd%0d_fetchl T=%0d ctl=%b Fault=%b exp F=%b", n, T, ctl, Fault, fault_exp); end
            Enable = 1'($urandom);
            step();
            checks++; if (T !== 3'd1 || ctl !== exp_ctl(1'b1, 1'b1) || Fault !== 1'b0) begin failures++; $display("FAIL rnd%0d_fetchh T=%0d ctl=%b Fault=%b", n, T, ctl, Fault); end
            Enable = 1'($urandom);
            step();
            checks++; if (IROut !== w || Opcode !== w[15:12] || pc !== 8'(exp_pc + 8'd2)) begin failures++; $display("FAIL rnd%0d_ir IR=%h op=%h pc=%h exp %h %h %h", n, IROut, Opcode, pc, w, w[15:12], 8'(exp_pc + 8'd2)); end
            for (int t = 2; t <= t_end; t++) begin
                checks++; if (T !== 3'(t) || ctl !== exp_ctl(1'b0, 1'b0)) begin failures++; $display("FAIL rnd%0d_exec T=%0d exp=%0d ctl=%b", n, T, t, ctl); end
                ExecDone = (t == done_at);
                Enable = (t == t_end) ? en : 1'($urandom);
                step();
            end
            ExecDone = 1'b0;
            exp_pc = 8'(exp_pc + 8'd2);
            fault_exp = (done_at == 8);
            $display("tb: rnd%0d instr=%h exec_cycles=%0d timeout=%0d enable=%0d", n, w, t_end - 1, fault_exp, en);
            if (!en) begin
                checks++; if (T !== 3'd0 || ctl !== exp_ctl(1'b0, 1'b0) || Fault !== fault_exp) begin failures++; $display("FAIL rnd%0d_idle T=%0d ctl=%b Fault=%b exp F=%b", n, T, ctl, Fault, fault_exp); end
                fault_exp = 1'b0;
                step();
                Enable = 1'b1;
                step();
            end
        end
    endtask

    task automatic test_halt;
        do_reset();
        set_pc(8'h20);
        mem[8'h20] = 8'h00; mem[8'h21] = 8'hF0;
        Enable = 1'b1;
        step(); step(); step();
        checks++; if (Opcode !== 4'hF || T !== 3'd2 || Halted !== 1'b0) begin failures++; $display("FAIL halt_exec op=%h T=%0d Halted=%b", Opcode, T, Halted); end
        ExecDone = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (Halted !== 1'b1 || ctl !== exp_ctl(1'b0, 1'b0) || T !== 3'd0 || pc !== 8'h22) begin failures++; $display("FAIL halt_hold%0d Halted=%b ctl=%b T=%0d pc=%h exp pc=22", i, Halted, ctl, T, pc); end
            ExecDone = 1'($urandom);
            step();
        end
        ExecDone = 1'b0;
        do_reset();
        checks++; if (Halted !== 1'b0 || ctl !== exp_ctl(1'b0, 1'b0)) begin failures++; $display("FAIL halt_reset Halted=%b ctl=%b", Halted, ctl); end
        $display("tb: halt done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_timeout();
        test_priority();
        test_enable_drop();
        test_async_reset();
        test_random();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and timing sequencer for the `ALU_System` datapath. It drives the ARF, IR and memory control lines to fetch each 16-bit instruction as two byte reads, low byte first. It then runs a timing counter T through the execute phase until the execute decoder signals completion. It also detects the halt opcode and times out runaway instructions.

## Interface
- `MAX_EXEC_CYCLES`, default 6: maximum execute cycles per instruction; legal range 1..6.
- `HALT_OPCODE`, default 4'hF: opcode value in `IROut[15:12]` that halts the sequencer.

- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `Enable`  in  1  run request; sampled only at instruction boundaries.
- `ExecDone`  in  1  from the execute decoder; the current EXEC cycle is the last one.
- `IROut`  in  16  IR contents.
- `ARF_FunSel`  out  2  00 decrement, 01 increment, 10 load, 11 clear.
- `ARF_RegSel`  out  4  active-low enables; bit3 = PC; 4'b1111 = none.
- `ARF_OutDSel`  out  2  address source; always 2'b00 (PC) during fetch.
- `IR_LH`  out  1  0 = low byte, 1 = high byte.
- `IR_Enable`  out  1  IR write enable.
- `IR_Funsel`  out  2  2'b10 = load.
- `Mem_CS`  out  1  active-low chip select.
- `Mem_WR`  out  1  0 = read.
- `T`  out  3  sequence counter.
- `Opcode`  out  4  `IROut[15:12]`.
- `Halted`  out  1  high while in HALT.
- `Fault`  out  1  one-cycle pulse on execute timeout.

## Operation
- States: IDLE, FETCH_L, FETCH_H, EXEC, HALT.
- **IDLE:** all controls inactive. `Enable`=1 → FETCH_L.
- **FETCH_L (T=0):** `Mem_CS`=0, `Mem_WR`=0, `ARF_OutDSel`=00, `IR_Enable`=1, `IR_LH`=0, `IR_Funsel`=10, `ARF_FunSel`=01, `ARF_RegSel`=4'b0111. This loads `M[PC]` into IR[7:0] and increments PC. → FETCH_H.
- **FETCH_H (T=1):** same controls with `IR_LH`=1, loading `M[PC+1]` into IR[15:8]; PC increments again. → EXEC.
- **EXEC (T ≥ 2):**
  - Memory is deselected (`Mem_CS`=1), IR is disabled, `ARF_RegSel`=4'b1111. The ARF, RF and ALU are driven by the external decoder from `T` and `Opcode`.
  - If T=2 and `Opcode`=`HALT_OPCODE`: → HALT. `ExecDone` is ignored in this cycle.
  - Else if `ExecDone`=1: → FETCH_L when `Enable`=1, → IDLE when `Enable`=0.
  - Else if T = 1+`MAX_EXEC_CYCLES`: timeout. Next state is chosen as for `ExecDone`, and `Fault` pulses in the following cycle.
  - Else: stay in EXEC; T increments.
- **HALT:** all controls inactive, `Halted`=1; left only via `Reset`.
- `Enable` falling mid-instruction does not abort it; the sequencer stops at the next boundary.
- T saturates at 7; it never wraps. T returns to 0 on every entry to FETCH_L, IDLE or HALT.

## Timing
- Reset values (applied asynchronously):
  - state = IDLE, T=0, `Halted`=0, `Fault`=0.
  - `Mem_CS`=1, `Mem_WR`=0, `IR_Enable`=0, `IR_LH`=0, `IR_Funsel`=00.
  - `ARF_RegSel`=4'b1111, `ARF_FunSel`=01, `ARF_OutDSel`=00.
- All control outputs are Moore decodes of state only. The datapath captures on the same rising edge that ends the state.
- `IROut` is valid from the first EXEC cycle (T=2). `Opcode` is a combinational slice, meaningful only in EXEC.
- Minimum instruction length is 3 cycles (FETCH_L, FETCH_H, one EXEC cycle with `ExecDone`). Maximum is 2+`MAX_EXEC_CYCLES`.
- `Reset` asserted in any state forces IDLE immediately, with no completion of partial writes. Release is synchronous to the next edge.
- `ExecDone` arriving in the same cycle as the timeout takes priority: no `Fault`.

## Structure
- Shared package `seq_pkg`:
  - state enum;
  - ARF function codes (DEC/INC/LOAD/CLR);
  - RegSel masks (`REGSEL_NONE`, `REGSEL_PC`);
  - `IR_LOAD`;
  - `T_FETCH_L`/`T_FETCH_H`/`T_EXEC0` = 0/1/2.
- One sub-module `seq_counter`: 3-bit counter with synchronous clear, increment and saturation, plus async reset.
- FSM and output decode live in `fetch_sequencer`.

## Test plan
- **Basic fetch:** `Reset` pulse, `Enable`=1, PC=8'h10, M[10]=8'h34, M[11]=8'h12, `ExecDone` at T=2 → IR=16'h1234, PC=8'h12, `Opcode`=1, T sequence 0,1,2,0.
- **Halt:** instruction 16'hF000 → `Halted`=1 from cycle 4 onward, `Mem_CS`=1, PC frozen at +2. `ExecDone` pulses are ignored.
- **Timeout:** `ExecDone` held 0 with `MAX_EXEC_CYCLES`=6 → EXEC spans T=2..7, then FETCH_L with `Fault`=1 for exactly one cycle.
- **Enable drop:** `Enable` deasserted during FETCH_H → instruction completes at `ExecDone`, then IDLE, T=0. Reasserting `Enable` resumes at the next PC.
- **Async reset mid-fetch:** `Reset` asserted mid-cycle in FETCH_H → `IR_Enable`=0, `Mem_CS`=1, `ARF_RegSel`=4'b1111 before the next edge; state IDLE.
- **Priority:** `ExecDone`=1 coincident with T=7 → FETCH_L, `Fault` stays 0.
